// File: rtl/switch_mcu_pkg.sv
// Shared constants for the switch MCU core: register-file geometry and the
// fixed mapping of ALU units onto register-file write ports.
package switch_mcu_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int XLEN    = 32;

  localparam int WP_LUI    = 0;
  localparam int WP_AUIPC  = 1;
  localparam int WP_OP     = 2;
  localparam int WP_OP_IMM = 3;
  localparam int WP_LOAD   = 4;
  localparam int WP_JAL    = 5;
  localparam int WP_JALR   = 6;
  localparam int WP_CSR    = 7;
  localparam int WP_COUNT  = 8;

endpackage : switch_mcu_pkg

// File: rtl/switch_mcu_regfile_wsel.sv
// Priority write selector: lowest-index enabled port with a non-x0 address
// wins; two or more enables in one cycle are reported as a collision.
module switch_mcu_regfile_wsel
  import switch_mcu_pkg::*;
#(
  parameter int NUM_WP = WP_COUNT
) (
  input  logic [NUM_WP-1:0]        wen,
  input  logic [NUM_WP*REG_AW-1:0] waddr,
  input  logic [NUM_WP*XLEN-1:0]   wdata,
  output logic                     sel_valid,
  output logic [REG_AW-1:0]        sel_addr,
  output logic [XLEN-1:0]          sel_data,
  output logic                     collision
);

  logic [NUM_WP-1:0] wen_low_cleared_s;

  // Lowest-index qualifying port takes the write.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = {REG_AW{1'b0}};
    sel_data  = {XLEN{1'b0}};
    for (int i = 0; i < NUM_WP; i++) begin
      if (!sel_valid && wen[i] && (waddr[i*REG_AW +: REG_AW] != {REG_AW{1'b0}})) begin
        sel_valid = 1'b1;
        sel_addr  = waddr[i*REG_AW +: REG_AW];
        sel_data  = wdata[i*XLEN +: XLEN];
      end else begin
        sel_valid = sel_valid;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  always_comb begin
    wen_low_cleared_s = wen & (wen - NUM_WP'(1));
    collision         = |wen_low_cleared_s;
  end

endmodule : switch_mcu_regfile_wsel

// File: rtl/switch_mcu_regfile.sv
// 32x32 integer register file with merged ALU write ports, two bypassed
// combinational read ports and a sticky/saturating write-collision monitor.
module switch_mcu_regfile
  import switch_mcu_pkg::*;
#(
  parameter int NUM_WP = WP_COUNT,
  parameter int CNT_W  = 8
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic [NUM_WP-1:0]        in_wen,
  input  logic [NUM_WP*REG_AW-1:0] in_waddr,
  input  logic [NUM_WP*XLEN-1:0]   in_wdata,
  input  logic [REG_AW-1:0]        in_raddr1,
  input  logic [REG_AW-1:0]        in_raddr2,
  output logic [XLEN-1:0]          out_rdata1,
  output logic [XLEN-1:0]          out_rdata2,
  input  logic                     in_clr_err,
  output logic                     out_collision,
  output logic [CNT_W-1:0]         out_collision_cnt
);

  logic [XLEN-1:0]   regs_r [REG_NUM];
  logic              armed_r;
  logic              collision_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              sel_valid_s;
  logic [REG_AW-1:0] sel_addr_s;
  logic [XLEN-1:0]   sel_data_s;
  logic              collision_s;
  logic              wr_en_s;
  logic [XLEN-1:0]   rdata1_s;
  logic [XLEN-1:0]   rdata2_s;

  switch_mcu_regfile_wsel #(
    .NUM_WP(NUM_WP)
  ) u_wsel (
    .wen       (in_wen),
    .waddr     (in_waddr),
    .wdata     (in_wdata),
    .sel_valid (sel_valid_s),
    .sel_addr  (sel_addr_s),
    .sel_data  (sel_data_s),
    .collision (collision_s)
  );

  // armed_r stays low for the first edge after reset release so that edge never writes.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= 1'b1;
    end
  end

  assign wr_en_s = sel_valid_s & armed_r;

  // Architectural array; entry 0 is pinned to zero.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      regs_r[0] <= {XLEN{1'b0}};
      for (int i = 1; i < REG_NUM; i++) begin
        if (wr_en_s && (sel_addr_s == REG_AW'(i))) begin
          regs_r[i] <= sel_data_s;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Collision status; clear beats a simultaneous collision.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      collision_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else if (in_clr_err) begin
      collision_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else if (collision_s && armed_r) begin
      collision_r <= 1'b1;
      if (cnt_r != {CNT_W{1'b1}}) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      collision_r <= collision_r;
      cnt_r       <= cnt_r;
    end
  end

  // Read port 1 with bypass from the winning write only.
  always_comb begin
    rdata1_s = {XLEN{1'b0}};
    if (in_raddr1 == {REG_AW{1'b0}}) begin
      rdata1_s = {XLEN{1'b0}};
    end else if (wr_en_s && (sel_addr_s == in_raddr1)) begin
      rdata1_s = sel_data_s;
    end else begin
      rdata1_s = regs_r[in_raddr1];
    end
  end

  // Read port 2 with bypass from the winning write only.
  always_comb begin
    rdata2_s = {XLEN{1'b0}};
    if (in_raddr2 == {REG_AW{1'b0}}) begin
      rdata2_s = {XLEN{1'b0}};
    end else if (wr_en_s && (sel_addr_s == in_raddr2)) begin
      rdata2_s = sel_data_s;
    end else begin
      rdata2_s = regs_r[in_raddr2];
    end
  end

  assign out_rdata1        = rdata1_s;
  assign out_rdata2        = rdata2_s;
  assign out_collision     = collision_r;
  assign out_collision_cnt = cnt_r;

endmodule : switch_mcu_regfile

// File: tb/tb_switch_mcu_regfile.sv
// Self-checking bench: directed scenarios plus random traffic against an
// array-based reference model; a second instance runs with a 2-bit counter.
module tb_switch_mcu_regfile;
  import switch_mcu_pkg::*;

  localparam int NWP = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NWP-1:0]    wen;
  logic [NWP*5-1:0]  waddr;
  logic [NWP*32-1:0] wdata;
  logic [4:0]        ra1, ra2;
  logic              clr;
  logic [31:0]       rd1_a, rd2_a, rd1_b, rd2_b;
  logic              coll_a, coll_b;
  logic [7:0]        cnt_a;
  logic [1:0]        cnt_b;

  logic [31:0] mregs [32];
  bit          marmed;
  bit          mcoll;
  int          mcnt8, mcnt2;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  switch_mcu_regfile #(.NUM_WP(NWP), .CNT_W(8)) u_dut8 (
    .in_clk(clk), .in_rst(rst), .in_wen(wen), .in_waddr(waddr), .in_wdata(wdata),
    .in_raddr1(ra1), .in_raddr2(ra2), .out_rdata1(rd1_a), .out_rdata2(rd2_a),
    .in_clr_err(clr), .out_collision(coll_a), .out_collision_cnt(cnt_a)
  );

  switch_mcu_regfile #(.NUM_WP(NWP), .CNT_W(2)) u_dut2 (
    .in_clk(clk), .in_rst(rst), .in_wen(wen), .in_waddr(waddr), .in_wdata(wdata),
    .in_raddr1(ra1), .in_raddr2(ra2), .out_rdata1(rd1_b), .out_rdata2(rd2_b),
    .in_clr_err(clr), .out_collision(coll_b), .out_collision_cnt(cnt_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected read value from the rules: x0 is zero, winning write bypasses, else array.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    int w = -1;
    for (int i = 0; i < NWP; i++)
      if (w < 0 && wen[i] && waddr[i*5 +: 5] != 5'd0) w = i;
    if (a == 5'd0) return 32'd0;
    if (marmed && w >= 0 && waddr[w*5 +: 5] == a) return wdata[w*32 +: 32];
    return mregs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    marmed = 1'b0;
    mcoll  = 1'b0;
    mcnt8  = 0;
    mcnt2  = 0;
  endtask

  task automatic model_edge();
    int w = -1;
    for (int i = 0; i < NWP; i++)
      if (w < 0 && wen[i] && waddr[i*5 +: 5] != 5'd0) w = i;
    if (marmed && w >= 0) mregs[waddr[w*5 +: 5]] = wdata[w*32 +: 32];
    if (clr) begin
      mcoll = 1'b0; mcnt8 = 0; mcnt2 = 0;
    end else if (marmed && $countones(wen) > 1) begin
      mcoll = 1'b1;
      if (mcnt8 < 255) mcnt8++;
      if (mcnt2 < 3) mcnt2++;
    end
    marmed = 1'b1;
  endtask

  task automatic check_reads();
    check_val("rd1", rd1_a, exp_read(ra1));
    check_val("rd2", rd2_a, exp_read(ra2));
    check_val("rd1_c2", rd1_b, exp_read(ra1));
    check_val("rd2_c2", rd2_b, exp_read(ra2));
  endtask

  task automatic check_status();
    check_val("coll", {31'd0, coll_a}, {31'd0, mcoll});
    check_val("cnt", {24'd0, cnt_a}, mcnt8);
    check_val("coll_c2", {31'd0, coll_b}, {31'd0, mcoll});
    check_val("cnt_c2", {30'd0, cnt_b}, mcnt2);
  endtask

  // Called just after a falling edge with inputs set: check, clock, check.
  task automatic cycle();
    #1 check_reads();
    @(posedge clk);
    model_edge();
    #1 check_status();
    @(negedge clk);
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; clr = 1'b0;
  endtask

  task automatic set_wp(input int p, input logic [4:0] a, input logic [31:0] d);
    wen[p] = 1'b1;
    waddr[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  initial begin
    idle();
    ra1 = 5'd0; ra2 = 5'd0;
    model_reset();
    #12;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1 check_reads();
    end
    check_status();
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // Single write with same-cycle bypass.
    set_wp(WP_LUI, 5'd5, 32'h12345000); ra1 = 5'd5; ra2 = 5'd6;
    #1 check_val("byp_x5", rd1_a, 32'h12345000);
    check_val("x6_zero", rd2_a, 32'h0);
    cycle();
    idle();
    #1 check_val("x5_after", rd1_a, 32'h12345000);
    cycle();

    // Write to x0 is discarded.
    set_wp(WP_OP, 5'd0, 32'hFFFFFFFF); ra1 = 5'd0;
    cycle();
    idle();
    cycle();
    check_val("x0_nocoll", {31'd0, coll_a}, 32'd0);

    // Collision: lower port wins.
    set_wp(WP_AUIPC, 5'd7, 32'hAAAA0000); set_wp(WP_OP_IMM, 5'd7, 32'h00005555); ra1 = 5'd7;
    #1 check_val("byp_x7", rd1_a, 32'hAAAA0000);
    cycle();
    check_val("coll1", {31'd0, coll_a}, 32'd1);
    check_val("cnt1", {24'd0, cnt_a}, 32'd1);
    idle();
    #1 check_val("x7_after", rd1_a, 32'hAAAA0000);
    cycle();

    // Saturation of the narrow counter and clear-beats-collision.
    for (int k = 0; k < 5; k++) begin
      idle(); set_wp(0, 5'(k + 10), $urandom); set_wp(4, 5'd0, $urandom);
      cycle();
    end
    check_val("sat_c2", {30'd0, cnt_b}, 32'd3);
    check_val("cnt8_6", {24'd0, cnt_a}, 32'd6);
    idle(); set_wp(2, 5'd3, 32'h1); set_wp(6, 5'd4, 32'h2); clr = 1'b1;
    cycle();
    check_val("clr_flag", {31'd0, coll_b}, 32'd0);
    check_val("clr_cnt", {30'd0, cnt_b}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      case ($urandom_range(0, 3))
        0: wen = '0;
        1: wen = NWP'($urandom);
        default: wen = NWP'(1) << $urandom_range(0, NWP - 1);
      endcase
      for (int p = 0; p < NWP; p++) begin
        waddr[p*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wdata[p*32 +: 32] = $urandom;
      end
      clr = ($urandom_range(0, 15) == 0);
      ra1 = 5'($urandom);
      ra2 = ($urandom_range(0, 1) == 1) ? waddr[5*$urandom_range(0, NWP - 1) +: 5] : 5'($urandom);
      cycle();
    end

    // Asynchronous reset between edges, then a write on the release edge.
    idle(); set_wp(0, 5'd9, 32'hDEADBEEF);
    cycle();
    idle(); ra1 = 5'd9;
    #1 check_val("x9_set", rd1_a, 32'hDEADBEEF);
    #2 rst = 1'b0;
    model_reset();
    #1 check_val("x9_rst", rd1_a, 32'h0);
    check_status();
    @(negedge clk);
    rst = 1'b1;
    set_wp(0, 5'd9, 32'h0BADF00D);
    cycle();
    idle();
    #1 check_val("x9_norel", rd1_a, 32'h0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_switch_mcu_regfile

// File: doc/switch_mcu_regfile.md
# switch_mcu_regfile

Integer register file for the switch MCU core, directly downstream of the ALU execution units. It merges the registered write ports (`waddr`/`wen`/`wdata`) of all ALU units into the 32×32 architectural register set. It serves two read ports to the decoder/ALU operand path, with same-cycle write bypass. It detects and counts illegal multi-unit write collisions.

## Interface
Parameters:
- `NUM_WP`, default 8: number of ALU write ports merged (LUI, AUIPC, OP, OP-IMM, LOAD, JAL, JALR, CSR).
- `CNT_W`, default 8: width of the saturating collision counter.

Ports:
- `in_clk`  in  1  single clock; all state updates on rising edge.
- `in_rst`  in  1  asynchronous, active-low reset.
- `in_wen`  in  NUM_WP  per-unit write enable; bit i belongs to unit i.
- `in_waddr`  in  NUM_WP*5  packed write addresses; slice i is `[5i+4:5i]`.
- `in_wdata`  in  NUM_WP*32  packed write data; slice i is `[32i+31:32i]`.
- `in_raddr1`  in  5  read port 1 address (rs1).
- `in_raddr2`  in  5  read port 2 address (rs2).
- `out_rdata1`  out  32  read port 1 data, combinational.
- `out_rdata2`  out  32  read port 2 data, combinational.
- `in_clr_err`  in  1  synchronous clear of the collision status.
- `out_collision`  out  1  sticky flag: a multi-port write collision has occurred.
- `out_collision_cnt`  out  CNT_W  saturating count of collision cycles.

## Operation
- Storage: x1..x31 are 32-bit flops. x0 is not stored, reads as 0, and writes to it are discarded.
- Write select, per cycle:
  - Find the lowest index i with `in_wen[i]=1` and `waddr_i != 0`.
  - That port writes `wdata_i` to `regs[waddr_i]` at the next rising edge.
  - Any other enabled ports in the same cycle are dropped.
- Collision: two or more `in_wen` bits high in the same cycle, regardless of address, including x0.
  - On a collision cycle, set `out_collision` and increment `out_collision_cnt`.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
- `in_clr_err`:
  - Clears the flag and counter at the next edge.
  - If a collision occurs in the same cycle, clear wins for that edge. The collision is not recorded.
- Read path, evaluated per port independently:
  - If raddr = 0, output 0.
  - Otherwise, if the selected write is active and its address equals raddr, output the selected write data (bypass).
  - Otherwise, output `regs[raddr]`.
- Bypass uses only the winning port, never a dropped one.

## Timing
- Reset (in_rst=0, asynchronous): x1..x31 = 0, `out_collision` = 0, `out_collision_cnt` = 0. Read outputs therefore return 0 for all addresses.
- Reset asserted mid-write: the write is lost and the register stays 0. No write occurs on the edge that coincides with reset release.
- Write latency: data presented in cycle N is visible from the array in cycle N+1. Via bypass it is visible combinationally in cycle N.
- Read latency: 0 cycles (combinational from raddr and write inputs).
- No handshake. Write ports are fire-and-forget, and every enabled non-x0 winning write completes in one cycle.
- The ALU units drive at most one `wen` per instruction, on their commit cycle. A collision therefore indicates a decoder or sequencer fault, not normal traffic.

## Structure
- Shared package `switch_mcu_pkg`:
  - `REG_NUM=32`, `REG_AW=5`, `XLEN=32`.
  - Write-port index constants (`WP_LUI`, `WP_AUIPC`, …), so ALU-to-port mapping is fixed in one place.
- Sub-module `switch_mcu_regfile_wsel`: a combinational priority selector. It takes packed wen/waddr/wdata and produces sel_valid, sel_addr, sel_data, and collision. It is instantiated once and is reused by the bypass logic.
- The array, read muxes and status counter live in the top module.

## Test plan
- Reset then read: hold in_rst=0, then release. Reading every raddr 0..31 on both ports returns 0x00000000. Collision flag and count are 0.
- Single write plus bypass: port 0 writes addr 5 with data 0x12345000. raddr1=5 reads 0x12345000 in the same cycle and in the next cycle. raddr2=6 reads 0.
- x0 discard: port 2 writes addr 0 with 0xFFFFFFFF. raddr1=0 reads 0 now and afterwards. No collision is flagged.
- Collision: ports 1 and 3 both enabled in the same cycle, addr 7 with 0xAAAA0000 and addr 7 with 0x5555, respectively.
  - x7 = 0xAAAA0000 after the edge.
  - `out_collision`=1 and cnt=1.
  - Bypass shows 0xAAAA0000 during the cycle.
- Saturation and clear, with CNT_W=2:
  - Five collision cycles leave cnt=3.
  - Asserting `in_clr_err` together with a collision gives flag=0 and cnt=0.
- Async reset mid-operation: write x9=0xDEADBEEF, then pulse in_rst low between edges. x9 reads 0 immediately, and a write pending on the reset-release edge is not stored.
